// File: rtl/shift_sequencer.sv
// Expands one register command (clear, inc/dec by N, shift/rotate by N) into a
// train of single-cycle control pulses for the downstream general-purpose register.
module shift_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int AW         = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [AW-1:0]         amount,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] reg_out,
  output logic                  cl,
  output logic                  inc,
  output logic                  dec,
  output logic                  sr,
  output logic                  sl,
  output logic                  ir,
  output logic                  il,
  output logic                  busy,
  output logic                  done
);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_CLR = 3'b001;
  localparam logic [2:0] OP_INC = 3'b010;
  localparam logic [2:0] OP_DEC = 3'b011;
  localparam logic [2:0] OP_LSR = 3'b100;
  localparam logic [2:0] OP_ASR = 3'b101;
  localparam logic [2:0] OP_LSL = 3'b110;
  localparam logic [2:0] OP_ROR = 3'b111;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [2:0]    op_q;
  logic [AW-1:0] cnt_q;

  // Only the end bits feed the fill logic; the rest of the feedback bus is idle.
  logic unused_reg_bits;
  assign unused_reg_bits = ^reg_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_q  <= '0;
      cnt_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op_q <= op;
          if (op == OP_NOP || (amount == '0 && op != OP_CLR)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= RUN;
            busy  <= 1'b1;
            cnt_q <= (op == OP_CLR) ? AW'(1) : amount;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - AW'(1);
            if (cnt_q == AW'(1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Fill bits follow the live register so each pulse of a multi-bit ASR/ROR
  // sees the result of the previous one.
  always_comb begin
    cl  = 1'b0;
    inc = 1'b0;
    dec = 1'b0;
    sr  = 1'b0;
    sl  = 1'b0;
    ir  = 1'b0;
    il  = 1'b0;
    if (state == RUN) begin
      case (op_q)
        OP_ASR:  ir = reg_out[DATA_WIDTH-1];
        OP_ROR:  ir = reg_out[0];
        default: ir = 1'b0;
      endcase
      if (!abort) begin
        case (op_q)
          OP_CLR:                 cl  = 1'b1;
          OP_INC:                 inc = 1'b1;
          OP_DEC:                 dec = 1'b1;
          OP_LSR, OP_ASR, OP_ROR: sr  = 1'b1;
          OP_LSL:                 sl  = 1'b1;
          default:                ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: a behavioural register closes the loop,
// a scoreboard queue holds expected results that a monitor checks on done.
module tb_shift_sequencer;
  localparam int DW = 16;
  localparam int AW = $clog2(DW) + 1;
  localparam int K_SL = 0, K_SR = 1, K_DEC = 2, K_INC = 3, K_CL = 4;

  logic clk = 1'b0;
  logic rst, start, abort;
  logic [2:0] op;
  logic [AW-1:0] amount;
  logic [DW-1:0] gpr;
  logic cl, inc, dec, sr, sl, ir, il, busy, done;
  logic load_en;
  logic [DW-1:0] load_val;

  typedef struct {
    logic [DW-1:0] val;
    int n, kind, nir;
    time t0;
    int b_all, b_kind, b_busy, b_ir;
  } exp_t;
  exp_t q[$];

  int n_chk = 0, n_fail = 0;
  int cnt[5] = '{0, 0, 0, 0, 0};
  int n_pulse = 0, n_busy = 0, n_ir = 0, n_done = 0;

  shift_sequencer #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .amount(amount), .abort(abort),
    .reg_out(gpr), .cl(cl), .inc(inc), .dec(dec), .sr(sr), .sl(sl), .ir(ir), .il(il),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural general-purpose register driven by the sequencer pulses.
  always @(posedge clk) begin
    if (load_en)  gpr <= load_val;
    else if (cl)  gpr <= '0;
    else if (inc) gpr <= gpr + 16'd1;
    else if (dec) gpr <= gpr - 16'd1;
    else if (sr)  gpr <= {ir, gpr[DW-1:1]};
    else if (sl)  gpr <= {gpr[DW-2:0], il};
  end

  task automatic chk(input string name, input int act, input int expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, expv, expv, $time);
    end
  endtask

  // Monitor: per-cycle sanity plus scoreboard pop on every done.
  always @(negedge clk) begin : mon
    logic [4:0] p;
    exp_t e;
    int lat;
    p = {cl, inc, dec, sr, sl};
    chk("onehot", int'($countones(p) <= 1), 1);
    if (!busy) begin
      chk("idle_pulses", int'(p), 0);
      chk("idle_fill", int'({ir, il}), 0);
    end
    for (int k = 0; k < 5; k++) cnt[k] += int'(p[k]);
    n_pulse += $countones(p);
    n_busy  += int'(busy);
    if (sr && ir) n_ir++;
    if (done) begin
      n_done++;
      chk("done_expected", int'(q.size() > 0), 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        lat = int'(($time - e.t0 + 5) / 10);
        chk("reg_value", int'(gpr), int'(e.val));
        chk("pulse_total", n_pulse - e.b_all, e.n);
        chk("pulse_kind", cnt[e.kind] - e.b_kind, e.n);
        chk("busy_cycles", n_busy - e.b_busy, e.n);
        chk("fill_ones", n_ir - e.b_ir, e.nir);
        chk("done_latency", lat, e.n + 1);
      end
    end
  end

  task automatic load(input logic [DW-1:0] v);
    load_en = 1'b1; load_val = v;
    @(posedge clk); #1 load_en = 1'b0;
  endtask

  task automatic run_cmd(input logic [2:0] o, input int amt, input logic [DW-1:0] val,
                         input int n, input int kind, input int nir);
    exp_t e;
    int d0;
    start = 1'b1; op = o; amount = amt[AW-1:0];
    e.val = val; e.n = n; e.kind = kind; e.nir = nir;
    e.b_all = n_pulse; e.b_kind = cnt[kind]; e.b_busy = n_busy; e.b_ir = n_ir;
    d0 = n_done;
    @(posedge clk); e.t0 = $time; q.push_back(e); #1 start = 1'b0;
    for (int i = 0; i < 60 && n_done == d0; i++) begin @(posedge clk); #1; end
    chk("done_seen", n_done - d0, 1);
  endtask

  initial begin
    int b_sl, b_inc, b_dec, d0;
    rst = 1'b1; start = 1'b0; op = '0; amount = '0; abort = 1'b0;
    load_en = 1'b0; load_val = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", int'({cl, inc, dec, sr, sl, ir, il, busy, done}), 0);
    @(posedge clk); #1 rst = 1'b0;

    load(16'h0005); run_cmd(3'b010, 3,  16'h0008, 3, K_INC, 0);
    load(16'h8001); run_cmd(3'b101, 4,  16'hF800, 4, K_SR,  4);
    load(16'h8001); run_cmd(3'b100, 4,  16'h0800, 4, K_SR,  0);
    load(16'h1234); run_cmd(3'b111, 16, 16'h1234, 16, K_SR, 5);
    load(16'h1234); run_cmd(3'b111, 4,  16'h4123, 4, K_SR,  1);
    run_cmd(3'b001, 7, 16'h0000, 1, K_CL, 0);
    load(16'h0042); run_cmd(3'b011, 0, 16'h0042, 0, K_DEC, 0);
    run_cmd(3'b000, 5, 16'h0042, 0, K_INC, 0);
    run_cmd(3'b010, 2, 16'h0044, 2, K_INC, 0);

    // LSL by 8 aborted in its third RUN cycle, with a stray start mid-run.
    load(16'h00FF);
    b_sl = cnt[K_SL]; b_inc = cnt[K_INC]; d0 = n_done;
    start = 1'b1; op = 3'b110; amount = 5'd8;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 start = 1'b1; op = 3'b010; amount = 5'd1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("abort_reg", int'(gpr), 16'h03FC);
    chk("abort_sl_pulses", cnt[K_SL] - b_sl, 2);
    chk("abort_no_inc", cnt[K_INC] - b_inc, 0);
    chk("abort_no_done", n_done - d0, 0);

    // Synchronous reset in the middle of DEC by 10.
    @(posedge clk); #1;
    load(16'h0100);
    b_dec = cnt[K_DEC]; d0 = n_done;
    start = 1'b1; op = 3'b011; amount = 5'd10;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_outputs", int'({cl, inc, dec, sr, sl, ir, il, busy, done}), 0);
    chk("rst_mid_reg", int'(gpr), 16'h00FC);
    chk("rst_mid_dec_pulses", cnt[K_DEC] - b_dec, 4);
    repeat (2) @(posedge clk);
    #1 chk("rst_mid_no_done", n_done - d0, 0);
    run_cmd(3'b010, 1, 16'h00FD, 1, K_INC, 0);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
